uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter on the core's data bus, beside the word-addressed RAM. Decodes core bus accesses in a 16-byte window and buffers written bytes in a FIFO. Serialises bytes onto a single `tx` line with a programmable bit period. Read data is registered with the same one-cycle latency as RAM, so the bus returns `dout` as a simple OR of all slaves.

## Interface
- `BASE_ADDR`, default 32'h0000_1000: window base; must be 16-byte aligned.
- `CLK_DIV`, default 16: reset value of DIVISOR, in clock cycles per bit.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`, in, 1: single clock; all state updates on posedge.
- `rst`, in, 1: asynchronous, active-low reset.
- `addr`, in, 32: core byte address.
- `din`, in, 32: core write data.
- `write_en`, in, 1: core write strobe, sampled at posedge.
- `dout`, out, 32: registered read data; 0 when the previous-cycle address missed the window.
- `tx`, out, 1: serial output, idle high.

## Operation
- Hit = `addr[31:4] == BASE_ADDR[31:4]`; `addr[3:2]` selects the register; `addr[1:0]` is ignored.
- 0x0 TXDATA:
  - Write pushes `din[7:0]`.
  - If the FIFO is full, the byte is dropped and OVF is set.
  - Reads return 0.
- 0x4 STATUS, read:
  - bit0 BUSY: FSM not IDLE.
  - bit1 FULL.
  - bit2 EMPTY.
  - bit3 OVF: sticky.
  - bits[11:8]: FIFO count.
  - Others 0.
- 0x4 STATUS, write: writing 1 to bit3 clears OVF; all other bits are ignored.
- 0x8 DIVISOR: read/write, 16-bit in `din[15:0]`. A written value below 2 is stored as 2.
- 0xC: reserved; writes ignored, reads 0.
- FULL is evaluated before any same-cycle pop, so a push to a full FIFO is dropped even if the FSM pops in that cycle.
- A simultaneous push and pop on a non-full FIFO leaves count unchanged.
- FSM states:
  - IDLE → START when the FIFO is non-empty: pop the head into the shift register and latch DIVISOR into the frame divisor.
  - START (`tx`=0, 1 bit period) → DATA.
  - DATA: 8 bits, LSB first, 1 bit period each → PARITY if enabled, else STOP.
  - PARITY → STOP.
  - STOP (`tx`=1, 1 bit period) → IDLE.
- A bit counter counts 0..frame_div-1 and advances state/bit index at terminal count.
- A DIVISOR write mid-frame affects only the next frame.
- With FIFO non-empty, IDLE lasts exactly one cycle between frames.

## Timing
- Reset (async, `rst`=0):
  - `tx`=1, `dout`=0, FSM=IDLE.
  - FIFO empty, OVF=0, DIVISOR=CLK_DIV.
  - Reset mid-frame aborts the frame immediately; `tx` goes high without waiting for a clock.
- Read latency: `dout` is valid after the posedge following address presentation. A write cycle to the window also updates `dout` with the read value of that address, taken before the write.
- Write to TXDATA at edge k, FIFO empty, IDLE:
  - EMPTY=0 after k.
  - Pop and START at edge k+1, so `tx` falls after k+1.
- Frame length: 10×N cycles (11×N with parity), where N = latched divisor.
- BUSY is 1 from the pop edge until the STOP period ends.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is compiled in and transmits even parity (XOR of the 8 data bits) between the last data bit and stop.
  - STATUS bit4 reads 1.
- Macro undefined: no PARITY state, 10-bit frames, STATUS bit4 reads 0.

## Test plan
- Reset values: assert `rst`=0 mid-frame → `tx`=1 immediately. After release, a STATUS read returns 0x0000_0004 and a DIVISOR read returns 16.
- Single byte:
  - Setup: DIVISOR=4, write 0xA5 to 0x1000.
  - Expect `tx` low for 4 cycles starting one edge after the write.
  - Then bits 1,0,1,0,0,1,0,1, 4 cycles each, then 4 high cycles.
  - BUSY clears 40 cycles after the pop.
- Overflow:
  - Write 10 bytes back-to-back with DIVISOR=100. The first pops, the FIFO holds 8, one is dropped.
  - Expect OVF=1 and count=8.
  - Write 0x8 to STATUS → OVF=0.
- Back-to-back frames: queue 0x00 and 0xFF with DIVISOR=2 → exactly one idle cycle between frames, total 41 cycles from first START.
- Divisor change: write DIVISOR=8 during a frame sent at DIVISOR=3 → current frame stays at 3 cycles/bit, next frame at 8. Writing DIVISOR=0 reads back 2.
- Parity (`UART_TX_PARITY_EN`): send 0x07 → parity bit 1, 11-bit frame. Out-of-window read → `dout`=0.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: 16-byte register window, byte FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop (11-bit frames).
`timescale 1ns/1ps
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        write_en,
  output logic [31:0] dout,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [15:0]   DIV_RST = 16'(CLK_DIV);

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_FLAG = 1'b1;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  localparam logic PAR_FLAG = 1'b0;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  logic          hit_s;
  logic [1:0]    sel_s;
  logic          wr_data_s, wr_stat_s, wr_div_s;
  logic          push_s, drop_s, pop_s;
  logic          full_s, empty_s, busy_s;
  logic [3:0]    cnt4_s;
  logic [31:0]   read_val_s;
  logic          unused_s;

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r;
  logic [15:0]   divisor_r;

  state_t        state_r, state_n;
  logic [15:0]   cnt_r, cnt_n;
  logic [2:0]    idx_r, idx_n;
  logic [7:0]    shift_r, shift_n;
  logic [15:0]   frame_div_r, frame_div_n;
  logic          tx_n;
  logic          bit_end_s;
`ifdef UART_TX_PARITY_EN
  logic          parity_r, parity_n;
`endif

  assign hit_s    = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel_s    = addr[3:2];
  assign unused_s = ^{addr[1:0], din[31:16]};
  assign full_s   = (count_r == DEPTH_C);
  assign empty_s  = (count_r == {CW{1'b0}});
  assign busy_s   = (state_r != ST_IDLE);
  assign cnt4_s   = 4'(count_r);
  assign push_s   = wr_data_s && !full_s;
  assign drop_s   = wr_data_s && full_s;
  assign bit_end_s = (cnt_r == (frame_div_r - 16'd1));

  // Register-select decode of bus writes
  always_comb begin
    wr_data_s = 1'b0;
    wr_stat_s = 1'b0;
    wr_div_s  = 1'b0;
    if (write_en && hit_s) begin
      case (sel_s)
        2'd0:    wr_data_s = 1'b1;
        2'd1:    wr_stat_s = 1'b1;
        2'd2:    wr_div_s  = 1'b1;
        default: wr_data_s = 1'b0;
      endcase
    end else begin
      wr_data_s = 1'b0;
    end
  end

  // Read mux; register values are pre-write, so a write cycle returns the old contents
  always_comb begin
    read_val_s = 32'd0;
    case (sel_s)
      2'd1:    read_val_s = {20'd0, cnt4_s, 3'd0, PAR_FLAG, ovf_r, empty_s, full_s, busy_s};
      2'd2:    read_val_s = {16'd0, divisor_r};
      default: read_val_s = 32'd0;
    endcase
  end

  // Registered read data, zero on a window miss so slaves can be OR-ed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= 32'd0;
    end else begin
      dout <= hit_s ? read_val_s : 32'd0;
    end
  end

  // FIFO storage (contents are don't-care while empty, so no reset)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag and divisor register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r     <= 1'b0;
      divisor_r <= DIV_RST;
    end else begin
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (wr_stat_s && din[3]) begin
        ovf_r <= 1'b0;
      end
      if (wr_div_s) begin
        divisor_r <= (din[15:0] < 16'd2) ? 16'd2 : din[15:0];
      end
    end
  end

  // Serialiser next state; tx is computed for the next state so it is a clean register output
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    idx_n       = idx_r;
    shift_n     = shift_r;
    frame_div_n = frame_div_r;
    tx_n        = 1'b1;
    pop_s       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_n    = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_n     = ST_START;
          shift_n     = mem_r[rd_ptr_r];
          frame_div_n = divisor_r;
          cnt_n       = 16'd0;
          tx_n        = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_n    = even_parity(mem_r[rd_ptr_r]);
`endif
        end else begin
          tx_n = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_n = ST_DATA;
          cnt_n   = 16'd0;
          idx_n   = 3'd0;
          tx_n    = shift_r[0];
        end else begin
          cnt_n = cnt_r + 16'd1;
          tx_n  = 1'b0;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_n = 16'd0;
          if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = ST_PARITY;
            tx_n    = parity_r;
`else
            state_n = ST_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n   = idx_r + 3'd1;
            shift_n = {1'b0, shift_r[7:1]};
            tx_n    = shift_r[1];
          end
        end else begin
          cnt_n = cnt_r + 16'd1;
          tx_n  = shift_r[0];
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          state_n = ST_STOP;
          cnt_n   = 16'd0;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt_r + 16'd1;
          tx_n  = parity_r;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end_s) begin
          state_n = ST_IDLE;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
        tx_n = 1'b1;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = 16'd0;
        tx_n    = 1'b1;
      end
    endcase
  end

  // Serialiser state register; reset forces the line idle immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 16'd0;
      idx_r       <= 3'd0;
      shift_r     <= 8'd0;
      frame_div_r <= DIV_RST;
      tx          <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      idx_r       <= idx_n;
      shift_r     <= shift_n;
      frame_div_r <= frame_div_n;
      tx          <= tx_n;
`ifdef UART_TX_PARITY_EN
      parity_r    <= parity_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: read data and per-cycle tx samples are queued
// by the stimulus and checked by an independent monitor.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef UART_TX_PARITY_EN
  localparam logic [31:0] PAR_BIT = 32'h0000_0010;
  localparam bit          PAR_ON  = 1'b1;
`else
  localparam logic [31:0] PAR_BIT = 32'h0000_0000;
  localparam bit          PAR_ON  = 1'b0;
`endif
  localparam int BITS = PAR_ON ? 11 : 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] din;
  logic        write_en;
  logic [31:0] dout;
  logic        tx;

  uart_tx_mmio dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .din      (din),
    .write_en (write_en),
    .dout     (dout),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] rd_exp_q [$];
  string       rd_name_q [$];
  logic        tx_exp_q [$];
  string       tx_name_q [$];
  bit          rd_flag = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares dout one edge after a flagged read, and tx after every edge
  initial begin : monitor
    bit pend;
    string nm;
    logic [31:0] ev;
    logic tv;
    forever begin
      @(posedge clk);
      pend = rd_flag;
      #1;
      if (pend && rd_exp_q.size() > 0) begin
        nm = rd_name_q.pop_front();
        ev = rd_exp_q.pop_front();
        check(nm, dout, ev);
      end
      if (tx_exp_q.size() > 0) begin
        nm = tx_name_q.pop_front();
        tv = tx_exp_q.pop_front();
        check(nm, {31'd0, tx}, {31'd0, tv});
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; din = d; write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0; addr = 32'h0; din = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string nm);
    addr = a; write_en = 1'b0;
    rd_exp_q.push_back(e);
    rd_name_q.push_back(nm);
    rd_flag = 1'b1;
    @(negedge clk);
    rd_flag = 1'b0; addr = 32'h0;
  endtask

  task automatic push_tx(input logic v, input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      tx_exp_q.push_back(v);
      tx_name_q.push_back(nm);
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input int n, input string nm);
    push_tx(1'b0, n, {nm, "_start"});
    for (int i = 0; i < 8; i++) push_tx(b[i], n, $sformatf("%s_d%0d", nm, i));
    if (PAR_ON) push_tx(^b, n, {nm, "_par"});
    push_tx(1'b1, n, {nm, "_stop"});
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (tx_exp_q.size() > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("tx_drain", 32'(tx_exp_q.size()), 32'd0);
    tx_exp_q.delete();
    tx_name_q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b0; addr = 32'h0; din = 32'h0; write_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_dout", dout, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of a frame with a byte still queued
    bus_write(BASE, 32'h55);
    bus_write(BASE, 32'h66);
    repeat (5) @(negedge clk);
    check("start_low", {31'd0, tx}, 32'd0);
    #2 rst = 1'b0;
    #1 check("async_tx", {31'd0, tx}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_read(BASE + 32'h4, 32'h4 | PAR_BIT, "status_rst");
    bus_read(BASE + 32'h8, 32'd16, "div_rst");
    bus_read(BASE + 32'h0, 32'd0, "txdata_rd");
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
    bus_read(BASE + 32'hC, 32'd0, "rsvd_rd");
    bus_read(BASE + 32'h8, 32'd16, "div_after_rsvd");
    check("idle_after_rst", {31'd0, tx}, 32'd1);

    // Single byte 0xA5 at 4 cycles/bit
    bus_write(BASE + 32'h8, 32'd4);
    bus_write(BASE, 32'hA5);
    push_frame(8'hA5, 4, "a5");
    repeat (BITS * 4) @(negedge clk);
    bus_read(BASE + 32'h4, 32'h5 | PAR_BIT, "busy_last");
    bus_read(BASE + 32'h4, 32'h4 | PAR_BIT, "busy_clear");
    wait_drain(2000);

    // Back-to-back frames with a single idle cycle between them
    bus_write(BASE + 32'h8, 32'd2);
    bus_write(BASE, 32'h00);
    push_frame(8'h00, 2, "b2b0");
    push_tx(1'b1, 1, "b2b_idle");
    push_frame(8'hFF, 2, "b2b1");
    bus_write(BASE, 32'hFF);
    wait_drain(2000);

    // Divisor change mid-frame applies to the next frame only
    bus_write(BASE + 32'h8, 32'hFFFF_0003);
    bus_read(BASE + 32'h8, 32'd3, "div_mask");
    bus_write(BASE, 32'h3C);
    push_frame(8'h3C, 3, "div3");
    push_tx(1'b1, 1, "div_idle");
    push_frame(8'hC3, 8, "div8");
    bus_write(BASE, 32'hC3);
    repeat (6) @(negedge clk);
    bus_write(BASE + 32'h8, 32'd8);
    bus_read(BASE + 32'h8, 32'd8, "div_new");
    wait_drain(3000);
    bus_write(BASE + 32'h8, 32'd0);
    bus_read(BASE + 32'h8, 32'd2, "div_zero");
    bus_write(BASE + 32'h8, 32'd1);
    bus_read(BASE + 32'h8 + 32'h3, 32'd2, "div_one");

    // Byte 0x07: odd popcount, so the parity bit is 1 when enabled
    bus_write(BASE, 32'h07);
    push_frame(8'h07, 2, "p07");
    wait_drain(2000);

    // Overflow: one pops, eight fill the FIFO, the tenth is dropped
    bus_write(BASE + 32'h8, 32'd100);
    for (int i = 0; i < 10; i++) bus_write(BASE, 32'h10 + 32'(i));
    bus_read(BASE + 32'h4, 32'h80B | PAR_BIT, "ovf_set");
    bus_write(BASE + 32'h4, 32'h7);
    bus_read(BASE + 32'h4, 32'h80B | PAR_BIT, "ovf_keep");
    bus_write(BASE + 32'h4, 32'h8);
    bus_read(BASE + 32'h4, 32'h803 | PAR_BIT, "ovf_clr");
    bus_read(32'h0000_2000, 32'd0, "oow_far");
    bus_read(BASE + 32'h8, 32'd100, "div_100");
    bus_read(BASE + 32'h10, 32'd0, "oow_above");

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_read(BASE + 32'h4, 32'h4 | PAR_BIT, "flush");
    repeat (3) @(negedge clk);
    check("rd_queue_empty", 32'(rd_exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
